mem_slot_arbiter: RTL and testbench

MEM_SLOT_ARBITER -- requirements
Module: mem_slot_arbiter

---
 rtl/mem_slot_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_slot_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_slot_arbiter.sv
// Time-slotted arbiter sharing one byte-wide memory port between CPU, video and DMA.
// Each slot owner has priority; an unused slot goes to the first requester in CPU > VID > DMA order.
module mem_slot_arbiter #(
  parameter int ADDR_W  = 21,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce_16mhz,
  input  logic              ce_4mhz,
  input  logic              cpu_req,
  input  logic              vid_req,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              cpu_we,
  input  logic              dma_we,
  input  logic [7:0]        cpu_wdata,
  input  logic [7:0]        dma_wdata,
  output logic              cpu_ack,
  output logic              vid_ack,
  output logic              dma_ack,
  output logic [7:0]        rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // Memory handshake: mem_req rises after a grant and holds address/we/wdata
  // stable until the clk after mem_ack (or the timeout), when it drops.
  typedef enum logic { IDLE = 1'b0, BUSY = 1'b1 } state_e;
  typedef enum logic [1:0] { PORT_CPU = 2'd0, PORT_VID = 2'd1, PORT_DMA = 2'd2 } port_e;

  state_e            state_q, state_d;
  port_e             port_q, port_d;
  port_e             owner, grant;
  logic [1:0]        slot_q, slot_d, dec_slot;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_req, any_req;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [2:0]        ack_q, ack_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              err_q, err_d;

  // Slot bookkeeping and the winner for a decision taken on this clk.
  always_comb begin
    slot_d = slot_q;
    if (ce_4mhz) begin
      slot_d = 2'd0;
    end else if (ce_16mhz) begin
      slot_d = slot_q + 2'd1;
    end

    dec_slot = ce_4mhz ? 2'd0 : slot_q + 2'd1;
    case (dec_slot)
      2'd1:    owner = PORT_VID;
      2'd3:    owner = PORT_DMA;
      default: owner = PORT_CPU;
    endcase

    case (owner)
      PORT_VID: owner_req = vid_req;
      PORT_DMA: owner_req = dma_req;
      default:  owner_req = cpu_req;
    endcase

    any_req = cpu_req | vid_req | dma_req;
    if (owner_req)    grant = owner;
    else if (cpu_req) grant = PORT_CPU;
    else if (vid_req) grant = PORT_VID;
    else              grant = PORT_DMA;
  end

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    ack_d       = 3'b000;
    rdata_d     = rdata_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (ce_16mhz && any_req) begin
          state_d   = BUSY;
          port_d    = grant;
          cnt_d     = '0;
          mem_req_d = 1'b1;
          case (grant)
            PORT_VID: begin
              mem_addr_d  = vid_addr;
              mem_we_d    = 1'b0;
              mem_wdata_d = 8'h00;
            end
            PORT_DMA: begin
              mem_addr_d  = dma_addr;
              mem_we_d    = dma_we;
              mem_wdata_d = dma_wdata;
            end
            default: begin
              mem_addr_d  = cpu_addr;
              mem_we_d    = cpu_we;
              mem_wdata_d = cpu_wdata;
            end
          endcase
        end
      end
      BUSY: begin
        // A mem_ack on the timeout clk still completes normally.
        if (mem_ack || (cnt_q == CNT_W'(TIMEOUT))) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (mem_ack) begin
            rdata_d = mem_rdata;
          end else begin
            rdata_d = 8'hFF;
            err_d   = 1'b1;
          end
          case (port_q)
            PORT_VID: ack_d = 3'b010;
            PORT_DMA: ack_d = 3'b100;
            default:  ack_d = 3'b001;
          endcase
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      port_q      <= PORT_CPU;
      slot_q      <= 2'd0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 8'h00;
      ack_q       <= 3'b000;
      rdata_q     <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      slot_q      <= slot_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign cpu_ack   = ack_q[0];
  assign vid_ack   = ack_q[1];
  assign dma_ack   = ack_q[2];
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_slot_arbiter.sv
// Directed bench for mem_slot_arbiter: a table of single accesses plus hand-written
// sequences for slot rotation, stray mem_ack, and reset during an access.
module tb_mem_slot_arbiter;

  logic        clk;
  logic        reset_n;
  logic        ce_16mhz, ce_4mhz;
  logic        cpu_req, vid_req, dma_req;
  logic [20:0] cpu_addr, vid_addr, dma_addr;
  logic        cpu_we, dma_we;
  logic [7:0]  cpu_wdata, dma_wdata;
  logic        cpu_ack, vid_ack, dma_ack;
  logic [7:0]  rdata;
  logic        mem_req;
  logic [20:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        err;

  mem_slot_arbiter #(.ADDR_W(21), .TIMEOUT(15)) dut (
    .clk(clk), .reset_n(reset_n), .ce_16mhz(ce_16mhz), .ce_4mhz(ce_4mhz),
    .cpu_req(cpu_req), .vid_req(vid_req), .dma_req(dma_req),
    .cpu_addr(cpu_addr), .vid_addr(vid_addr), .dma_addr(dma_addr),
    .cpu_we(cpu_we), .dma_we(dma_we), .cpu_wdata(cpu_wdata), .dma_wdata(dma_wdata),
    .cpu_ack(cpu_ack), .vid_ack(vid_ack), .dma_ack(dma_ack), .rdata(rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
  );

  // clock / reset / strobes
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] ph;
  assign ce_16mhz = (ph[1:0] == 2'd3);
  assign ce_4mhz  = (ph[3:0] == 4'hF);

  wire [2:0] acks = {dma_ack, vid_ack, cpu_ack};

  int   n_vec, n_err, cyc;
  logic ce_prev;
  int   mem_delay, mem_age;
  bit   mem_done;
  logic [7:0] mem_val;

  typedef struct {
    int          sync;
    logic [2:0]  req;
    logic        cpu_we, dma_we;
    logic [20:0] cpu_addr, vid_addr, dma_addr;
    logic [7:0]  cpu_wdata, dma_wdata, mem_val;
    int          delay;
    logic [2:0]  exp_ack;
    logic [20:0] exp_addr;
    logic        exp_we;
    logic [7:0]  exp_wdata, exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: advance strobes, then model memory that acks mem_delay clks after mem_req rises.
  task automatic tick();
    ce_prev = ce_16mhz;
    @(negedge clk);
    ph  = ph + 8'd1;
    cyc = cyc + 1;
    mem_ack   = 1'b0;
    mem_rdata = 8'hEE;
    if (!mem_req) begin
      mem_age  = 0;
      mem_done = 0;
    end else if (!mem_done) begin
      if (mem_age == mem_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_val;
        mem_done  = 1;
      end
      mem_age++;
    end
  endtask

  task automatic run_vector(input vec_t v, input int idx);
    bit seen, got, stable;
    seen = 0; got = 0; stable = 1;
    if (v.sync >= 0) begin
      for (int k = 0; k < 16 && ph[3:0] != 4'(v.sync); k++) tick();
    end
    cpu_addr = v.cpu_addr; vid_addr = v.vid_addr; dma_addr = v.dma_addr;
    cpu_we = v.cpu_we; dma_we = v.dma_we;
    cpu_wdata = v.cpu_wdata; dma_wdata = v.dma_wdata;
    mem_delay = v.delay; mem_val = v.mem_val;
    {dma_req, vid_req, cpu_req} = v.req;
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      if (mem_req && !seen) begin
        seen = 1;
        check($sformatf("v%0d grant_on_ce", idx), 32'(ce_prev), 32'd1);
        check($sformatf("v%0d mem_addr", idx), 32'(mem_addr), 32'(v.exp_addr));
        check($sformatf("v%0d mem_we", idx), 32'(mem_we), 32'(v.exp_we));
        check($sformatf("v%0d mem_wdata", idx), 32'(mem_wdata), 32'(v.exp_wdata));
      end else if (mem_req && (mem_addr !== v.exp_addr || mem_we !== v.exp_we ||
                               mem_wdata !== v.exp_wdata)) begin
        stable = 0;
      end
      if (acks != 3'b000) begin
        got = 1;
        check($sformatf("v%0d acks", idx), 32'(acks), 32'(v.exp_ack));
        check($sformatf("v%0d rdata", idx), 32'(rdata), 32'(v.exp_rdata));
        check($sformatf("v%0d err", idx), 32'(err), 32'(v.exp_err));
        check($sformatf("v%0d mem_req_low", idx), 32'(mem_req), 32'd0);
        {dma_req, vid_req, cpu_req} = 3'b000;
      end
    end
    check($sformatf("v%0d ack_seen", idx), 32'(got), 32'd1);
    check($sformatf("v%0d busy_stable", idx), 32'(stable), 32'd1);
    repeat (2) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] order[4];
    int         at[4];
    int         n_ack;
    bit         seen, got, quiet;

    n_vec = 0; n_err = 0; cyc = 0; ph = 8'd0; ce_prev = 1'b0;
    mem_delay = -1; mem_age = 0; mem_done = 0; mem_val = 8'h00;
    mem_ack = 1'b0; mem_rdata = 8'h00;
    reset_n = 1'b0;
    cpu_req = 0; vid_req = 0; dma_req = 0;
    cpu_addr = '0; vid_addr = '0; dma_addr = '0;
    cpu_we = 0; dma_we = 0; cpu_wdata = 8'h00; dma_wdata = 8'h00;

    //          sync req    cwe dwe cpu_addr     vid_addr     dma_addr     cwd    dwd    mval   dly  ack     addr         we  wdata  rdata  err
    vecs[0]  = '{-1, 3'b100, 0, 1, 21'h000010, 21'h000020, 21'h012345, 8'h11, 8'hA5, 8'h00,  2, 3'b100, 21'h012345, 1, 8'hA5, 8'h00, 0};
    vecs[1]  = '{-1, 3'b010, 0, 0, 21'h000010, 21'h00ABCD, 21'h000030, 8'h11, 8'h22, 8'h3C,  1, 3'b010, 21'h00ABCD, 0, 8'h00, 8'h3C, 0};
    vecs[2]  = '{-1, 3'b001, 0, 0, 21'h1FFFFF, 21'h000000, 21'h000000, 8'h77, 8'h00, 8'h5A,  0, 3'b001, 21'h1FFFFF, 0, 8'h77, 8'h5A, 0};
    vecs[3]  = '{-1, 3'b001, 1, 0, 21'h000000, 21'h000001, 21'h000002, 8'hFF, 8'h00, 8'h11,  3, 3'b001, 21'h000000, 1, 8'hFF, 8'h11, 0};
    vecs[4]  = '{15, 3'b101, 0, 1, 21'h000100, 21'h000000, 21'h000200, 8'h01, 8'h02, 8'h22,  2, 3'b001, 21'h000100, 0, 8'h01, 8'h22, 0};
    vecs[5]  = '{15, 3'b110, 0, 1, 21'h000000, 21'h000300, 21'h000400, 8'h00, 8'h03, 8'h33,  2, 3'b010, 21'h000300, 0, 8'h00, 8'h33, 0};
    vecs[6]  = '{11, 3'b101, 0, 1, 21'h000500, 21'h000000, 21'h000600, 8'h05, 8'h06, 8'h34,  2, 3'b100, 21'h000600, 1, 8'h06, 8'h34, 0};
    vecs[7]  = '{-1, 3'b001, 0, 0, 21'h005555, 21'h000000, 21'h000000, 8'h00, 8'h00, 8'h44, 14, 3'b001, 21'h005555, 0, 8'h00, 8'h44, 0};
    vecs[8]  = '{-1, 3'b001, 0, 0, 21'h00AAAA, 21'h000000, 21'h000000, 8'h00, 8'h00, 8'h66, 15, 3'b001, 21'h00AAAA, 0, 8'h00, 8'h66, 0};
    vecs[9]  = '{-1, 3'b001, 0, 0, 21'h013579, 21'h000000, 21'h000000, 8'h00, 8'h00, 8'h99, -1, 3'b001, 21'h013579, 0, 8'h00, 8'hFF, 1};
    vecs[10] = '{-1, 3'b010, 0, 0, 21'h000000, 21'h002468, 21'h000000, 8'h00, 8'h00, 8'h81,  1, 3'b010, 21'h002468, 0, 8'h00, 8'h81, 1};
    vecs[11] = '{-1, 3'b100, 0, 0, 21'h000000, 21'h000000, 21'h01ABCD, 8'h00, 8'h5F, 8'h77, 16, 3'b100, 21'h01ABCD, 0, 8'h5F, 8'hFF, 1};

    // reset state
    repeat (3) tick();
    check("rst mem_req", 32'(mem_req), 32'd0);
    check("rst acks", 32'(acks), 32'd0);
    check("rst rdata", 32'(rdata), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst mem_addr", 32'(mem_addr), 32'd0);
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst mem_wdata", 32'(mem_wdata), 32'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 12; i++) run_vector(vecs[i], i);

    // stray mem_ack while idle: no ack, rdata keeps its last value
    tick();
    mem_ack = 1'b1;
    mem_rdata = 8'h99;
    quiet = 1;
    repeat (3) begin
      tick();
      if (acks != 3'b000) quiet = 0;
    end
    check("idle_ack no_ack", 32'(quiet), 32'd1);
    check("idle_ack rdata_held", 32'(rdata), 32'hFF);

    // reset during an outstanding access
    cpu_addr = 21'h000777; cpu_we = 0; cpu_wdata = 8'h00;
    mem_delay = -1; mem_val = 8'h00;
    cpu_req = 1'b1;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      seen = mem_req;
    end
    check("rstbusy reached_busy", 32'(seen), 32'd1);
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    check("rstbusy mem_req", 32'(mem_req), 32'd0);
    check("rstbusy acks", 32'(acks), 32'd0);
    check("rstbusy err_cleared", 32'(err), 32'd0);
    check("rstbusy rdata", 32'(rdata), 32'd0);
    check("rstbusy slot_q", 32'(dut.slot_q), 32'd0);
    mem_delay = 1; mem_val = 8'h5C;
    repeat (2) tick();
    for (int k = 0; k < 4 && ph[1:0] != 2'd0; k++) tick();
    reset_n = 1'b1;
    seen = 0; got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (mem_req && !seen) begin
        seen = 1;
        check("rstbusy grant_on_ce", 32'(ce_prev), 32'd1);
        check("rstbusy mem_addr", 32'(mem_addr), 32'h777);
      end
      if (acks != 3'b000) begin
        got = 1;
        check("rstbusy acks_after", 32'(acks), 32'b001);
        check("rstbusy rdata_after", 32'(rdata), 32'h5C);
        cpu_req = 1'b0;
      end
    end
    check("rstbusy ack_seen", 32'(got), 32'd1);
    repeat (2) tick();

    // CPU and VID held: slots 0..3 grant CPU, VID, CPU, CPU on consecutive strobes
    cpu_addr = 21'h000C00; vid_addr = 21'h000D00;
    mem_delay = 2; mem_val = 8'hC1;
    for (int i = 0; i < 4; i++) begin
      order[i] = 3'b000;
      at[i] = 0;
    end
    n_ack = 0;
    for (int k = 0; k < 16 && ph[3:0] != 4'hF; k++) tick();
    cpu_req = 1'b1; vid_req = 1'b1;
    for (int k = 0; k < 40 && n_ack < 4; k++) begin
      tick();
      if (acks != 3'b000) begin
        order[n_ack] = acks;
        at[n_ack] = cyc;
        n_ack++;
        if (n_ack == 4) begin
          cpu_req = 1'b0; vid_req = 1'b0;
        end
      end
    end
    check("rot ack_count", 32'(n_ack), 32'd4);
    check("rot slot0", 32'(order[0]), 32'b001);
    check("rot slot1", 32'(order[1]), 32'b010);
    check("rot slot2", 32'(order[2]), 32'b001);
    check("rot slot3", 32'(order[3]), 32'b001);
    check("rot gap01", 32'(at[1] - at[0]), 32'd4);
    check("rot gap12", 32'(at[2] - at[1]), 32'd4);
    check("rot gap23", 32'(at[3] - at[2]), 32'd4);
    check("rot rdata", 32'(rdata), 32'hC1);
    repeat (4) tick();
    check("rot idle_after", 32'(mem_req), 32'd0);
    check("rot err", 32'(err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
